// File: rtl/ym3438_timing_pkg.sv
// Shared timing constants for the OPN2 slot sequencer.
// Also holds the slot -> (channel, operator) decode.
package ym3438_timing_pkg;

  localparam int         SLOTS     = 24;
  localparam logic [4:0] LAST_SLOT = 5'd23;

  localparam logic [7:0] REG_TEST = 8'h21;
  localparam logic [7:0] REG_LFO  = 8'h22;

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] op;
  } chop_t;

  // Slots are grouped six per operator: op = slot / 6, ch = slot mod 6.
  function automatic chop_t slot_to_chop(input logic [4:0] slot);
    chop_t r;
    if (slot >= 5'd18) begin
      r.op = 2'd3;
      r.ch = 3'(slot - 5'd18);
    end else if (slot >= 5'd12) begin
      r.op = 2'd2;
      r.ch = 3'(slot - 5'd12);
    end else if (slot >= 5'd6) begin
      r.op = 2'd1;
      r.ch = 3'(slot - 5'd6);
    end else begin
      r.op = 2'd0;
      r.ch = 3'(slot);
    end
    return r;
  endfunction

endpackage

// File: rtl/ym3438_clk_phase.sv
// MCLK prescaler producing the non-overlapping c1/c2 clock-enable pulses.
// adv flags the edge on which c1 fires, so the slot counter can step in lockstep.
module ym3438_clk_phase
  import ym3438_timing_pkg::*;
#(
  parameter int PRESCALE = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic c1,
  output logic c2,
  output logic adv
);

  localparam int              PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRE_HALF = PW'(PRESCALE / 2);

  if ((PRESCALE < 4) || ((PRESCALE % 2) != 0)) begin : g_bad_prescale
    $error("ym3438_clk_phase: PRESCALE must be even and at least 4");
  end

  logic [PW-1:0] pre_reg, pre_next;
  logic          c1_reg, c1_next;
  logic          c2_reg, c2_next;

  // Hold freezes the counter in place, so release resumes exactly where it stopped.
  always_comb begin
    pre_next = pre_reg;
    c1_next  = 1'b0;
    c2_next  = 1'b0;
    if (!hold) begin
      pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
      c1_next  = (pre_next == '0);
      c2_next  = (pre_next == PRE_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= PRE_LAST;
      c1_reg  <= 1'b0;
      c2_reg  <= 1'b0;
    end else begin
      pre_reg <= pre_next;
      c1_reg  <= c1_next;
      c2_reg  <= c2_next;
    end
  end

  assign adv = !hold && (pre_reg == PRE_LAST);
  assign c1  = c1_reg;
  assign c2  = c2_reg;

endmodule

// File: rtl/ym3438_slot_sequencer.sv
// OPN2 master timing: 24-slot operator counter with decoded strobes, plus the
// test register and a sample-aligned LFO configuration shadow.
module ym3438_slot_sequencer
  import ym3438_timing_pkg::*;
#(
  parameter int PRESCALE = 6,
  parameter int SLOTS    = 24
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       hold,
  input  logic       reg_wr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       c1,
  output logic       c2,
  output logic [4:0] slot,
  output logic       fsm_sel0,
  output logic       fsm_sel23,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       sample_tick,
  output logic [3:0] lfo,
  output logic [7:0] reg_21
);

  localparam logic [4:0] WRAP_SLOT = 5'(SLOTS - 1);

  logic       adv, boundary, wr_test, wr_lfo;
  logic [4:0] slot_reg, slot_next;
  chop_t      chop_next;
  logic [2:0] ch_reg;
  logic [1:0] op_reg;
  logic       sel0_reg, sel0_next;
  logic       sel23_reg, sel23_next;
  logic       tick_reg, tick_next;
  logic [3:0] lfo_reg, lfo_next;
  logic [3:0] lfo_pend_reg, lfo_pend_next;
  logic       pending_reg, pending_next;
  logic [7:0] reg21_reg, reg21_next;

  ym3438_clk_phase #(
    .PRESCALE(PRESCALE)
  ) u_clk_phase (
    .clk  (MCLK),
    .rst_n(IC),
    .hold (hold),
    .c1   (c1),
    .c2   (c2),
    .adv  (adv)
  );

  always_comb begin
    wr_test  = reg_wr && (reg_addr == REG_TEST);
    wr_lfo   = reg_wr && (reg_addr == REG_LFO);
    boundary = adv && (slot_reg == WRAP_SLOT);

    slot_next = slot_reg;
    if (adv) begin
      slot_next = boundary ? 5'd0 : slot_reg + 5'd1;
    end
    // Decoding from slot_next keeps the strobes aligned with the slot they describe.
    chop_next  = slot_to_chop(slot_next);
    sel0_next  = (slot_next == 5'd0);
    sel23_next = (slot_next == LAST_SLOT);
    tick_next  = boundary;

    reg21_next    = reg21_reg;
    lfo_next      = lfo_reg;
    lfo_pend_next = lfo_pend_reg;
    pending_next  = pending_reg;

    if (wr_test) begin
      reg21_next = reg_data;
    end

    // A write landing on the boundary edge is newer than any pending value, so it wins.
    if (boundary) begin
      if (wr_lfo) begin
        lfo_next = reg_data[3:0];
      end else if (pending_reg) begin
        lfo_next = lfo_pend_reg;
      end
      pending_next = 1'b0;
    end else if (wr_lfo) begin
      lfo_pend_next = reg_data[3:0];
      pending_next  = 1'b1;
    end
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      slot_reg     <= LAST_SLOT;
      ch_reg       <= 3'd5;
      op_reg       <= 2'd3;
      sel0_reg     <= 1'b0;
      sel23_reg    <= 1'b1;
      tick_reg     <= 1'b0;
      lfo_reg      <= 4'd0;
      lfo_pend_reg <= 4'd0;
      pending_reg  <= 1'b0;
      reg21_reg    <= 8'd0;
    end else begin
      slot_reg     <= slot_next;
      ch_reg       <= chop_next.ch;
      op_reg       <= chop_next.op;
      sel0_reg     <= sel0_next;
      sel23_reg    <= sel23_next;
      tick_reg     <= tick_next;
      lfo_reg      <= lfo_next;
      lfo_pend_reg <= lfo_pend_next;
      pending_reg  <= pending_next;
      reg21_reg    <= reg21_next;
    end
  end

  assign slot        = slot_reg;
  assign ch          = ch_reg;
  assign op          = op_reg;
  assign fsm_sel0    = sel0_reg;
  assign fsm_sel23   = sel23_reg;
  assign sample_tick = tick_reg;
  assign lfo         = lfo_reg;
  assign reg_21      = reg21_reg;

endmodule

// File: doc/ym3438_slot_sequencer.md
Name: ym3438_slot_sequencer

Overview:
- Master timing sequencer for the OPN2 core.
- Divides MCLK into the two-phase clock-enable pair c1/c2 and steps a 24-slot operator counter (one slot per internal cycle).
- Decodes the slot strobes fsm_sel0/fsm_sel23 and the ch/op indices.
- Holds the LFO configuration (reg 0x22) and test register (reg 0x21); the LFO setting changes only on a sample boundary, so the LFO counter and PM/AM path never see a mid-sample change.

Parameters:
- PRESCALE, 6: MCLK cycles per internal cycle; even, ≥4.
- SLOTS, 24: slots per sample; fixed at 24 in this design.

Ports:
- MCLK  in  1  master clock; all state on rising edge.
- IC  in  1  reset; asynchronous, active-low.
- hold  in  1  freezes the prescaler: no c1/c2 pulses, no slot advance.
- reg_wr  in  1  register write strobe, one MCLK.
- reg_addr  in  8  register address.
- reg_data  in  8  register data.
- c1  out  1  phase-1 clock enable, one-MCLK pulse per internal cycle.
- c2  out  1  phase-2 clock enable, one-MCLK pulse per internal cycle.
- slot  out  5  current slot, 0..23.
- fsm_sel0  out  1  slot==0.
- fsm_sel23  out  1  slot==23.
- ch  out  3  slot mod 6.
- op  out  2  slot div 6.
- sample_tick  out  1  one-MCLK pulse when slot wraps 23→0.
- lfo  out  4  committed LFO config: bit3 = enable, bits2:0 = rate.
- reg_21  out  8  test register.

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (IC=0, async) values:
  - prescaler pre = PRESCALE-1.
  - c1=0, c2=0, slot=23, fsm_sel23=1, fsm_sel0=0, ch=5, op=3.
  - sample_tick=0, lfo=0, reg_21=0, pending=0, lfo_pend=0.
- Prescaler: pre counts 0..PRESCALE-1 and wraps; it advances only when hold=0.
- Edge where pre becomes 0:
  - c1←1.
  - slot←(slot==23 ? 0 : slot+1).
  - fsm_sel0, fsm_sel23, ch, op updated from the new slot on the same edge.
- Edge where pre becomes PRESCALE/2: c2←1.
- Every other edge: c1←0, c2←0.
- c1 and c2 never overlap.
- Each pulse lasts exactly one MCLK.
- Spacing between pulses is PRESCALE/2 MCLK.
- First c1 comes on the first edge after IC deasserts, and starts slot 0.
- hold=1: pre and slot are frozen and c1/c2/sample_tick are forced to 0 from the next edge. Releasing hold resumes from the frozen pre; no pulse is skipped or duplicated.
- sample_tick=1 on the edge where slot goes 23→0; otherwise 0.
- Register writes (accepted regardless of hold):
  - Address 0x21: reg_21←reg_data on the next edge (immediate).
  - Address 0x22: lfo_pend←reg_data[3:0], pending←1.
  - Other addresses: ignored.
- LFO commit: on the sample-boundary edge (slot 23→0), if pending, lfo←lfo_pend and pending←0.
- Write of 0x22 on the same edge as the boundary: the new reg_data is committed directly (bypass) and pending ends 0.
- Multiple 0x22 writes before a boundary: the last one wins.
- Reset mid-sample: pending write is discarded; lfo=0.
- ch/op are pure functions of slot:
  - slot 0 → ch 0, op 0.
  - slot 6 → ch 0, op 1.
  - slot 23 → ch 5, op 3.

Decomposition:
- Shared package ym3438_timing_pkg holds:
  - SLOTS=24 and the last-slot constant 23.
  - Register address constants REG_TEST=8'h21 and REG_LFO=8'h22.
  - The slot-to-ch/op function.
- One sub-module, ym3438_clk_phase, is natural: it contains the prescaler plus the c1/c2 pulse generator and exposes the hold input. The slot counter and register shadow stay in the top.

Test Plan:
- Reset and cadence, PRESCALE=6: release IC, no hold.
  - c1 on MCLK 1, 7, 13…; c2 on MCLK 4, 10…
  - slot reads 0 at MCLK 1, 1 at MCLK 7.
  - fsm_sel23=1 in slot 23; sample_tick pulses every 144 MCLK.
- Wrap and decode: run 2 samples.
  - slot sequence 0..23,0; fsm_sel0 and fsm_sel23 one slot each.
  - (ch,op) = (5,3) at slot 23 and (0,0) at slot 0.
- Deferred LFO: write 0x22=8'h0B in slot 5.
  - lfo stays 0 until the 23→0 edge, then reads 4'hB.
  - A write of 0x21=8'h02 shows on reg_21 on the next MCLK.
- Coincident and multiple writes:
  - Write 0x22=8'h09, then 8'h0C in the same sample: commits 4'hC.
  - Write 0x22=8'h0F exactly on the boundary edge: lfo=4'hF, pending=0.
- Hold: assert hold for 10 MCLK at pre=2.
  - No c1/c2/sample_tick pulses while held; slot unchanged.
  - After release, next c2 comes 1 MCLK later (pre 3) and cadence is unchanged.
- Async reset mid-sample: pull IC low with a pending 0x22 write at slot 12, not aligned to an MCLK edge.
  - All outputs go to reset values immediately; lfo=0 and the pending value is never committed.
